// File: rtl/field_store.sv
// Double-buffered cell storage for the Game of Life core.
//
// Two FIELD_W x FIELD_H bit planes. The iterator reads one plane (i_read_field) through a
// zero-latency cell + 8-neighbour lookup. It writes the next generation into the other plane.
// A host edit port and a row-by-row clear engine modify the read plane. A registered display
// port also reads the read plane.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_read_field          plane being read: 0 = FIELD_A, 1 = FIELD_B
//   i_is_simulating       write-back enable
//   i_next_x/i_next_y     lookup coords -> o_next_cell_state, o_next_nbrs (combinational)
//   i_cur_x/i_cur_y       write-back coords, i_new_cell_state write-back value
//   i_wr_en/x/y/val       host cell write
//   i_clear, o_busy       clear request pulse, clear engine active
//   i_disp_x/i_disp_y     display coords -> o_disp_cell (1-cycle latency)
//
// Neighbour bits: 0=NW 1=N 2=NE 3=W 4=E 5=SW 6=S 7=SE, with toroidal wrap.
module field_store #(
  parameter int unsigned FIELD_W = 32,
  parameter int unsigned FIELD_H = 24,
  localparam int unsigned X_ADR_SIZE = $clog2(FIELD_W),
  localparam int unsigned Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read_field,
  input  logic                  i_is_simulating,
  input  logic [X_ADR_SIZE-1:0] i_next_x,
  input  logic [Y_ADR_SIZE-1:0] i_next_y,
  input  logic [X_ADR_SIZE-1:0] i_cur_x,
  input  logic [Y_ADR_SIZE-1:0] i_cur_y,
  input  logic                  i_new_cell_state,
  output logic                  o_next_cell_state,
  output logic [7:0]            o_next_nbrs,
  input  logic                  i_wr_en,
  input  logic [X_ADR_SIZE-1:0] i_wr_x,
  input  logic [Y_ADR_SIZE-1:0] i_wr_y,
  input  logic                  i_wr_val,
  input  logic                  i_clear,
  output logic                  o_busy,
  input  logic [X_ADR_SIZE-1:0] i_disp_x,
  input  logic [Y_ADR_SIZE-1:0] i_disp_y,
  output logic                  o_disp_cell
);

  localparam logic [X_ADR_SIZE-1:0] XLast = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] YLast = Y_ADR_SIZE'(FIELD_H - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // fld_q[plane][row][x]
  logic [FIELD_W-1:0] fld_q [2][FIELD_H];

  state_e                state_q, state_d;
  logic [Y_ADR_SIZE-1:0] row_q, row_d;
  logic                  target_q, target_d;
  logic                  disp_q;

  // ---------------------------------------------------------------------------
  // Neighbour lookup
  // ---------------------------------------------------------------------------
  logic                  next_ok;
  logic [X_ADR_SIZE-1:0] xm, xp;
  logic [Y_ADR_SIZE-1:0] ym, yp;
  logic [FIELD_W-1:0]    row_m, row_c, row_p;

  always_comb begin
    next_ok = (32'(i_next_x) < FIELD_W) && (32'(i_next_y) < FIELD_H);
    // Explicit wrap so non-power-of-two sizes work
    xm = (i_next_x == '0)    ? XLast : i_next_x - X_ADR_SIZE'(1);
    xp = (i_next_x == XLast) ? '0    : i_next_x + X_ADR_SIZE'(1);
    ym = (i_next_y == '0)    ? YLast : i_next_y - Y_ADR_SIZE'(1);
    yp = (i_next_y == YLast) ? '0    : i_next_y + Y_ADR_SIZE'(1);
    row_m = '0;
    row_c = '0;
    row_p = '0;
    o_next_cell_state = 1'b0;
    o_next_nbrs       = '0;
    if (next_ok) begin
      row_m = fld_q[i_read_field][ym];
      row_c = fld_q[i_read_field][i_next_y];
      row_p = fld_q[i_read_field][yp];
      o_next_cell_state = row_c[i_next_x];
      o_next_nbrs = {row_p[xp], row_p[i_next_x], row_p[xm],
                     row_c[xp], row_c[xm],
                     row_m[xp], row_m[i_next_x], row_m[xm]};
    end
  end

  // ---------------------------------------------------------------------------
  // Write qualification and display read
  // ---------------------------------------------------------------------------
  logic wb_en, host_en, clear_row, disp_ok, disp_cell;

  always_comb begin
    wb_en   = i_is_simulating && (32'(i_cur_x) < FIELD_W) && (32'(i_cur_y) < FIELD_H);
    host_en = i_wr_en && !i_is_simulating && (state_q == StIdle) && !i_clear &&
              (32'(i_wr_x) < FIELD_W) && (32'(i_wr_y) < FIELD_H);
    clear_row = (state_q == StClear);
    disp_ok   = (32'(i_disp_x) < FIELD_W) && (32'(i_disp_y) < FIELD_H);
    disp_cell = 1'b0;
    if (disp_ok) begin
      disp_cell = fld_q[i_read_field][i_disp_y][i_disp_x];
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (i_clear && !i_is_simulating) begin
          state_d  = StClear;
          row_d    = '0;
          target_d = i_read_field;
        end
      end
      StClear: begin
        if (row_q == YLast) begin
          state_d = StIdle;
          row_d   = '0;
        end else begin
          row_d = row_q + Y_ADR_SIZE'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      row_q    <= '0;
      target_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      target_q <= target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < FIELD_H; r++) begin
        fld_q[0][r] <= '0;
        fld_q[1][r] <= '0;
      end
      disp_q <= 1'b0;
    end else begin
      if (clear_row) begin
        fld_q[target_q][row_q] <= '0;
      end
      // Write-back targets the plane not being read, so lookups never see it mid-generation
      if (wb_en) begin
        fld_q[~i_read_field][i_cur_y][i_cur_x] <= i_new_cell_state;
      end
      if (host_en) begin
        fld_q[i_read_field][i_wr_y][i_wr_x] <= i_wr_val;
      end
      disp_q <= disp_cell;
    end
  end

  assign o_busy      = (state_q == StClear);
  assign o_disp_cell = disp_q;

endmodule

// File: tb/tb_field_store.sv
module tb_field_store;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_read_field, i_is_simulating;
  logic [2:0] i_next_x, i_next_y, i_cur_x, i_cur_y;
  logic       i_new_cell_state;
  logic       o_next_cell_state;
  logic [7:0] o_next_nbrs;
  logic       i_wr_en;
  logic [2:0] i_wr_x, i_wr_y;
  logic       i_wr_val, i_clear;
  logic       o_busy;
  logic [2:0] i_disp_x, i_disp_y;
  logic       o_disp_cell;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  field_store #(.FIELD_W(W), .FIELD_H(H)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_read_field      (i_read_field),
    .i_is_simulating   (i_is_simulating),
    .i_next_x          (i_next_x),
    .i_next_y          (i_next_y),
    .i_cur_x           (i_cur_x),
    .i_cur_y           (i_cur_y),
    .i_new_cell_state  (i_new_cell_state),
    .o_next_cell_state (o_next_cell_state),
    .o_next_nbrs       (o_next_nbrs),
    .i_wr_en           (i_wr_en),
    .i_wr_x            (i_wr_x),
    .i_wr_y            (i_wr_y),
    .i_wr_val          (i_wr_val),
    .i_clear           (i_clear),
    .o_busy            (o_busy),
    .i_disp_x          (i_disp_x),
    .i_disp_y          (i_disp_y),
    .o_disp_cell       (o_disp_cell)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic f, input int x, input int y);
    i_read_field = f;
    i_next_x = 3'(x);
    i_next_y = 3'(y);
    #1;
  endtask

  task automatic host_wr(input int x, input int y, input logic v);
    i_wr_en = 1'b1;
    i_wr_x  = 3'(x);
    i_wr_y  = 3'(y);
    i_wr_val = v;
    tick();
    i_wr_en = 1'b0;
  endtask

  // Every cell of plane f must be 0 except (sx,sy) which must be v
  task automatic check_plane(input string tag, input logic f, input int sx, input int sy,
                             input logic v);
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) begin
        look(f, x, y);
        check($sformatf("%s f%0d (%0d,%0d)", tag, f, x, y), 16'(o_next_cell_state),
              16'((x == sx && y == sy) ? v : 1'b0));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int f = 0; f < 2; f++) begin
      for (int y = 0; y < int'(H); y++) begin
        for (int x = 0; x < int'(W); x++) begin
          look(1'(f), x, y);
          check($sformatf("%s f%0d (%0d,%0d)", tag, f, x, y),
                {7'd0, o_next_cell_state, o_next_nbrs}, 16'h0000);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_read_field = 1'b0; i_is_simulating = 1'b0;
    i_next_x = '0; i_next_y = '0; i_cur_x = '0; i_cur_y = '0; i_new_cell_state = 1'b0;
    i_wr_en = 1'b0; i_wr_x = '0; i_wr_y = '0; i_wr_val = 1'b0; i_clear = 1'b0;
    i_disp_x = '0; i_disp_y = '0;

    // 1: reset
    tick();
    rst_n = 1'b1;
    check("rst busy", 16'(o_busy), 16'h0);
    check("rst disp", 16'(o_disp_cell), 16'h0);
    check_all_zero("rst cell/nbrs");

    // 2: host write (1,0)=1 into A
    i_read_field = 1'b0;
    host_wr(1, 0, 1'b1);
    look(1'b0, 0, 0);
    check("w10 nbrs@00", 16'(o_next_nbrs), 16'h10);
    check("w10 cell@00", 16'(o_next_cell_state), 16'h0);
    look(1'b0, 2, 0);
    check("w10 nbrs@20", 16'(o_next_nbrs), 16'h08);
    look(1'b0, 1, 0);
    check("w10 cell@10", 16'(o_next_cell_state), 16'h1);

    // 3: wrap via (7,5)=1
    host_wr(7, 5, 1'b1);
    look(1'b0, 0, 0);
    check("wrap nbrs@00", 16'(o_next_nbrs), 16'h11);
    look(1'b0, 6, 4);
    check("wrap nbrs@64", 16'(o_next_nbrs), 16'h80);
    look(1'b0, 0, 4);
    check("wrap nbrs@04", 16'(o_next_nbrs), 16'h20);
    look(1'b0, 0, 6);
    check("oob lookup", {7'd0, o_next_cell_state, o_next_nbrs}, 16'h0000);

    // 4: write-back into B while reading A
    i_read_field = 1'b0;
    i_is_simulating = 1'b1;
    i_cur_x = 3'd3; i_cur_y = 3'd2; i_new_cell_state = 1'b1;
    tick();
    i_is_simulating = 1'b0;
    look(1'b0, 3, 2);
    check("wb A unchanged", 16'(o_next_cell_state), 16'h0);
    look(1'b1, 3, 2);
    check("wb B(3,2)", 16'(o_next_cell_state), 16'h1);
    i_disp_x = 3'd3; i_disp_y = 3'd2;
    tick();
    check("disp B(3,2)", 16'(o_disp_cell), 16'h1);
    i_read_field = 1'b0; i_disp_x = 3'd7; i_disp_y = 3'd5;
    tick();
    check("disp A(7,5)", 16'(o_disp_cell), 16'h1);
    i_disp_y = 3'd6;
    tick();
    check("disp oob", 16'(o_disp_cell), 16'h0);

    // 5: fill A, clear it; write and re-clear during busy are ignored
    i_read_field = 1'b0;
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        host_wr(x, y, 1'b1);
    look(1'b0, 4, 3);
    check("fill A", {7'd0, o_next_cell_state, o_next_nbrs}, 16'h01ff);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    for (int c = 1; c <= int'(H); c++) begin
      check($sformatf("clr busy c%0d", c), 16'(o_busy), 16'h1);
      if (c == 2) begin
        i_wr_en = 1'b1; i_wr_x = 3'd0; i_wr_y = 3'd0; i_wr_val = 1'b1;
      end else if (c == 3) begin
        i_clear = 1'b1;
      end
      tick();
      i_wr_en = 1'b0;
      i_clear = 1'b0;
    end
    check("clr busy end", 16'(o_busy), 16'h0);
    check_plane("clr A", 1'b0, -1, -1, 1'b0);
    check_plane("clr B kept", 1'b1, 3, 2, 1'b1);

    // 6: reset mid-clear
    host_wr(2, 2, 1'b1);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    tick();
    tick();
    check("midclr busy", 16'(o_busy), 16'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midclr rst busy", 16'(o_busy), 16'h0);
    check_all_zero("midclr rst");

    // Host write while simulating is dropped; clear while simulating is ignored
    i_read_field = 1'b0;
    i_is_simulating = 1'b1;
    i_cur_x = 3'd0; i_cur_y = 3'd0; i_new_cell_state = 1'b0;
    i_wr_en = 1'b1; i_wr_x = 3'd5; i_wr_y = 3'd5; i_wr_val = 1'b1;
    i_clear = 1'b1;
    tick();
    i_wr_en = 1'b0; i_clear = 1'b0; i_is_simulating = 1'b0;
    check("sim clr ignored", 16'(o_busy), 16'h0);
    look(1'b0, 5, 5);
    check("sim wr dropped", 16'(o_next_cell_state), 16'h0);

    // Clear together with host write: clear wins
    i_clear = 1'b1;
    i_wr_en = 1'b1; i_wr_x = 3'd2; i_wr_y = 3'd3; i_wr_val = 1'b1;
    tick();
    i_clear = 1'b0; i_wr_en = 1'b0;
    check("clr+wr busy", 16'(o_busy), 16'h1);
    for (int c = 0; c < int'(H); c++) tick();
    check("clr+wr done", 16'(o_busy), 16'h0);
    look(1'b0, 2, 3);
    check("clr+wr dropped", 16'(o_next_cell_state), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
